imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Sits between the AXI4-Lite slave register file and the single-cycle RISC-V core.
- Consumes software-driven register outputs (mem reset, run, write trigger, data, address) and loads instruction words into an on-chip instruction memory.
- Serves the core's instruction fetch port and gates core execution through a CLEAR/IDLE/RUN state machine.

Parameters:
- DEPTH, 1024, instruction memory depth in 32-bit words (power of two).
- AW, 10, word-address width; equals log2(DEPTH).
- NOP_WORD, 32'h0000_0013, fill and idle value (addi x0,x0,0).

Ports:
- clk  in  1  system clock (driven from s00_axi_aclk)
- reset_n  in  1  asynchronous active-low reset
- mem_reset_n  in  1  software memory clear request, active-low level
- run_pc_in  in  1  software run request, level
- instruction_write  in  32  bit0 is the write trigger; bits 31:1 are ignored
- instruction_data  in  32  instruction word to store
- instruction_addr  in  32  byte address of the word
- fetch_addr  in  32  core PC, byte address
- fetch_instr  out  32  fetched instruction
- core_run  out  1  core PC enable
- load_count  out  16  number of accepted writes since the last clear
- load_err  out  1  sticky error flag
- state_o  out  2  current FSM state, for status readback

Behaviour:
- Reset values: state CLEAR, core_run=0, fetch_instr=NOP_WORD, load_count=0, load_err=0, clear pointer=0.
- Trigger detection:
  - Register instruction_write[0] and run_pc_in once each.
  - A write event is a 0->1 transition of instruction_write[0]; a run event is a 0->1 transition of run_pc_in.
  - The trigger is a level, so software must toggle it back to 0 before issuing the next write.
- FSM:
  - CLEAR: write NOP_WORD to word[ptr] each cycle, ptr++. When ptr==DEPTH-1 has been written and mem_reset_n=1, go to IDLE and clear load_count and load_err.
    - If mem_reset_n is held low, keep sweeping with ptr wrapping to 0.
    - Write events and run events in CLEAR are ignored, with no error.
  - IDLE, mem_reset_n=0: go to CLEAR with ptr=0.
  - IDLE, write event: accept only if addr[1:0]==0 and addr[31:AW+2]==0. On accept, write data at addr[AW+1:2] on the next clock edge and do load_count++ (saturates at 16'hFFFF). Otherwise set load_err and leave memory unchanged.
  - IDLE, run event: go to RUN; core_run=1 on the next cycle.
  - IDLE, write event and run event in the same cycle: perform the write first, and also enter RUN.
  - RUN: core_run=1.
    - run_pc_in=0 -> IDLE, core_run=0 on the next cycle.
    - mem_reset_n=0 -> CLEAR, core_run=0 on the next cycle; this takes priority over all other events.
    - A write event in RUN is rejected and sets load_err; memory is never modified while running.
- Fetch path:
  - Synchronous read with 1-cycle latency: fetch_instr(t+1) = mem[fetch_addr[AW+1:2]](t).
  - fetch_instr is NOP_WORD whenever the FSM was not in RUN at cycle t, or fetch_addr at t is out of range or misaligned.
- Reset mid-operation: an asynchronous return to the reset values. A clear in progress restarts from ptr=0 after reset.
- Memory has one write port (loader/clear) and one read port (fetch); no read-during-write hazard exists because RUN never writes.

Optional Feature:
- IMEM_READBACK_EN:
  - Defined: adds ports readback_addr (in, 32, byte address) and readback_data (out, 32). A second synchronous read port gives 1-cycle latency in any state; an out-of-range address returns 32'hDEAD_BEEF. Software uses it to verify loaded contents.
  - Undefined: both ports are absent and memory is single-read-port.

Decomposition:
- Package imem_pkg:
  - state encoding: CLEAR=2'd0, IDLE=2'd1, RUN=2'd2
  - NOP_WORD
  - BAD_READ_WORD (32'hDEAD_BEEF)
  - DEPTH/AW defaults
- Sub-module imem_ram: simple dual-port synchronous RAM (1W/1R, plus a second read port under IMEM_READBACK_EN), parameterised by DEPTH and width. The FSM, edge detection and counters stay in imem_loader.

Test Plan:
- Release reset with mem_reset_n=1 -> state_o=CLEAR for exactly DEPTH cycles, then IDLE; every word reads NOP_WORD once in RUN.
- In IDLE, write 32'h0050_0093 at addr 0x8 (trigger 0->1->0), then a run event with fetch_addr=0x8 -> load_count=1; fetch_instr=32'h0050_0093 one cycle after RUN is entered.
- Write at addr 0x6 and at addr 0x1000 (DEPTH=1024) -> load_err=1, load_count unchanged, both target words still NOP_WORD.
- In RUN, a write event at addr 0x0 -> load_err=1 and word 0 unchanged. Then run_pc_in=0 -> core_run=0 next cycle and fetch_instr=NOP_WORD.
- Assert reset_n low mid-CLEAR (ptr≈500) -> all outputs return to reset values immediately; after release, the clear takes a full DEPTH cycles again.
- With IMEM_READBACK_EN defined: load word 0x0 with 32'hCAFE_0013, then read back at addr 0x0 -> readback_data=32'hCAFE_0013 after 1 cycle; a readback at addr 0x2000 returns 32'hDEAD_BEEF.

Source files
------------

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared state encoding, fill words and address checks for the instruction memory loader.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam int unsigned DEPTH_DEF     = 1024;
  localparam int unsigned AW_DEF        = 10;
  localparam logic [31:0] NOP_WORD      = 32'h0000_0013;
  localparam logic [31:0] BAD_READ_WORD = 32'hDEAD_BEEF;

  // Byte address lies inside a DEPTH = 2**aw word memory.
  function automatic logic addr_in_range(input logic [31:0] a, input int unsigned aw);
    return ((a >> (aw + 2)) == 32'd0);
  endfunction

  function automatic logic word_addr_ok(input logic [31:0] a, input int unsigned aw);
    return (a[1:0] == 2'b00) && addr_in_range(a, aw);
  endfunction

endpackage

// File: rtl/imem_ram.sv
// rtl/imem_ram.sv - simple dual-port synchronous RAM, one write and one read port.
// IMEM_READBACK_EN adds a second synchronous read port.
module imem_ram
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned W     = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
`ifdef IMEM_READBACK_EN
  input  logic [AW-1:0] rb_addr,
  output logic [W-1:0]  rb_data,
`endif
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

`ifdef IMEM_READBACK_EN
  logic [W-1:0] rb_data_q;

  always_ff @(posedge clk) begin
    rb_data_q <= mem[rb_addr];
  end

  assign rb_data = rb_data_q;
`endif

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - software-driven instruction memory loader with CLEAR/IDLE/RUN gating of the core.
// IMEM_READBACK_EN adds a readback port for verifying loaded contents.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned AW       = AW_DEF,
  parameter logic [31:0] NOP_WORD = imem_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_reset_n,
  input  logic        run_pc_in,
  input  logic [31:0] instruction_write,
  input  logic [31:0] instruction_data,
  input  logic [31:0] instruction_addr,
  input  logic [31:0] fetch_addr,
`ifdef IMEM_READBACK_EN
  input  logic [31:0] readback_addr,
  output logic [31:0] readback_data,
`endif
  output logic [31:0] fetch_instr,
  output logic        core_run,
  output logic [15:0] load_count,
  output logic        load_err,
  output logic [1:0]  state_o
);

  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [15:0]   load_count_q, load_count_d;
  logic          load_err_q, load_err_d;
  logic          core_run_q, core_run_d;
  logic          wr_trig_q, run_trig_q;
  logic          fetch_ok_q, fetch_ok_d;

  logic          wr_evt, run_evt;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic [31:0]   ram_rdata;

  // Only bit 0 of the write register is the trigger.
  logic unused_wr_bits;
  assign unused_wr_bits = ^instruction_write[31:1];

  assign wr_evt  = instruction_write[0] & ~wr_trig_q;
  assign run_evt = run_pc_in & ~run_trig_q;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    load_count_d = load_count_q;
    load_err_d   = load_err_q;
    mem_we       = 1'b0;
    mem_waddr    = ptr_q;
    mem_wdata    = NOP_WORD;

    case (state_q)
      ST_CLEAR: begin
        mem_we = 1'b1;
        ptr_d  = ptr_q + AW'(1);
        if ((ptr_q == LAST_PTR) && mem_reset_n) begin
          state_d      = ST_IDLE;
          load_count_d = 16'd0;
          load_err_d   = 1'b0;
        end
      end
      ST_IDLE: begin
        if (!mem_reset_n) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end else begin
          if (wr_evt) begin
            if (word_addr_ok(instruction_addr, AW)) begin
              mem_we    = 1'b1;
              mem_waddr = instruction_addr[AW+1:2];
              mem_wdata = instruction_data;
              if (load_count_q != 16'hFFFF) begin
                load_count_d = load_count_q + 16'd1;
              end
            end else begin
              load_err_d = 1'b1;
            end
          end
          if (run_evt) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // A pending clear overrides every other event, including write errors.
        if (!mem_reset_n) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end else begin
          if (!run_pc_in) begin
            state_d = ST_IDLE;
          end
          if (wr_evt) begin
            load_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase

    core_run_d = (state_d == ST_RUN);
    fetch_ok_d = (state_q == ST_RUN) && word_addr_ok(fetch_addr, AW);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_CLEAR;
      ptr_q        <= '0;
      load_count_q <= 16'd0;
      load_err_q   <= 1'b0;
      core_run_q   <= 1'b0;
      wr_trig_q    <= 1'b0;
      run_trig_q   <= 1'b0;
      fetch_ok_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      load_count_q <= load_count_d;
      load_err_q   <= load_err_d;
      core_run_q   <= core_run_d;
      wr_trig_q    <= instruction_write[0];
      run_trig_q   <= run_pc_in;
      fetch_ok_q   <= fetch_ok_d;
    end
  end

`ifdef IMEM_READBACK_EN
  logic        rb_ok_q, rb_ok_d;
  logic [31:0] ram_rb_data;

  assign rb_ok_d = addr_in_range(readback_addr, AW);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rb_ok_q <= 1'b0;
    end else begin
      rb_ok_q <= rb_ok_d;
    end
  end

  assign readback_data = rb_ok_q ? ram_rb_data : BAD_READ_WORD;
`endif

  imem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (32)
  ) u_ram (
    .clk     (clk),
    .we      (mem_we),
    .waddr   (mem_waddr),
    .wdata   (mem_wdata),
    .raddr   (fetch_addr[AW+1:2]),
`ifdef IMEM_READBACK_EN
    .rb_addr (readback_addr[AW+1:2]),
    .rb_data (ram_rb_data),
`endif
    .rdata   (ram_rdata)
  );

  assign fetch_instr = fetch_ok_q ? ram_rdata : NOP_WORD;
  assign core_run    = core_run_q;
  assign load_count  = load_count_q;
  assign load_err    = load_err_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader with a fetch scoreboard.
module tb_imem_loader;

  localparam int DEPTH = 1024;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_reset_n;
  logic        run_pc_in;
  logic [31:0] instruction_write;
  logic [31:0] instruction_data;
  logic [31:0] instruction_addr;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_instr;
  logic        core_run;
  logic [15:0] load_count;
  logic        load_err;
  logic [1:0]  state_o;
`ifdef IMEM_READBACK_EN
  logic [31:0] readback_addr;
  logic [31:0] readback_data;
`endif

  imem_loader dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .mem_reset_n       (mem_reset_n),
    .run_pc_in         (run_pc_in),
    .instruction_write (instruction_write),
    .instruction_data  (instruction_data),
    .instruction_addr  (instruction_addr),
    .fetch_addr        (fetch_addr),
`ifdef IMEM_READBACK_EN
    .readback_addr     (readback_addr),
    .readback_data     (readback_data),
`endif
    .fetch_instr       (fetch_instr),
    .core_run          (core_run),
    .load_count        (load_count),
    .load_err          (load_err),
    .state_o           (state_o)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_mem [DEPTH];
  logic        exp_in_run = 1'b0;
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Drives one fetch cycle, predicts the word seen one edge later, then compares.
  task automatic fetch_step(input logic [31:0] a);
    logic [31:0] e;
    logic [31:0] got;
    fetch_addr = a;
    if (exp_in_run && a[1:0] == 2'b00 && a[31:12] == 20'd0) e = exp_mem[a[11:2]];
    else e = NOP;
    exp_q.push_back(e);
    step();
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      got = exp_q.pop_front();
      check("fetch_instr", fetch_instr, got);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    instruction_addr  = a;
    instruction_data  = d;
    instruction_write = 32'hFFFF_FFFF;
    step();
    instruction_write = 32'h0;
    step();
  endtask

  // Counts edges until the FSM leaves CLEAR; bounded so a stuck clear still reports.
  task automatic clear_len(input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (state_o == 2'd0 && n < 3000);
    check(tag, n, DEPTH);
    check("state_after_clear", state_o, 2'd1);
  endtask

  initial begin
    reset_n = 1'b0;
    mem_reset_n = 1'b1;
    run_pc_in = 1'b0;
    instruction_write = 32'h0;
    instruction_data = 32'h0;
    instruction_addr = 32'h0;
    fetch_addr = 32'h0;
`ifdef IMEM_READBACK_EN
    readback_addr = 32'h0;
`endif
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = NOP;

    repeat (3) step();
    check("rst_state", state_o, 2'd0);
    check("rst_core_run", core_run, 1'b0);
    check("rst_fetch", fetch_instr, NOP);
    check("rst_count", load_count, 16'd0);
    check("rst_err", load_err, 1'b0);

    reset_n = 1'b1;
    clear_len("clear_cycles_initial");

    // Every word reads NOP after the initial clear.
    run_pc_in = 1'b1;
    fetch_step(32'h0);
    exp_in_run = 1'b1;
    check("run_core_run", core_run, 1'b1);
    check("run_state", state_o, 2'd2);
    for (int i = 0; i < DEPTH; i++) fetch_step(i * 4);
    run_pc_in = 1'b0;
    fetch_step(32'h0);
    exp_in_run = 1'b0;
    check("stop_core_run", core_run, 1'b0);
    check("stop_state", state_o, 2'd1);

    do_write(32'h8, 32'h0050_0093);
    exp_mem[2] = 32'h0050_0093;
    check("good_write_count", load_count, 16'd1);
    check("good_write_err", load_err, 1'b0);
    do_write(32'h6, 32'h1111_1111);
    check("misaligned_err", load_err, 1'b1);
    check("misaligned_count", load_count, 16'd1);
    do_write(32'h1000, 32'h2222_2222);
    check("range_err", load_err, 1'b1);
    check("range_count", load_count, 16'd1);

    run_pc_in = 1'b1;
    fetch_step(32'h8);
    exp_in_run = 1'b1;
    fetch_step(32'h8);
    fetch_step(32'h4);
    fetch_step(32'h0);
    fetch_step(32'h6);
    fetch_step(32'h1008);
    fetch_step(32'hFFFF_FFFC);

    // Clear requested while running.
    mem_reset_n = 1'b0;
    run_pc_in = 1'b0;
    fetch_step(32'h8);
    exp_in_run = 1'b0;
    check("clr_core_run", core_run, 1'b0);
    check("clr_state", state_o, 2'd0);
    mem_reset_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = NOP;
    clear_len("clear_cycles_from_run");
    check("clr_count", load_count, 16'd0);
    check("clr_err", load_err, 1'b0);

    // Write and run events in the same cycle.
    instruction_addr = 32'h0;
    instruction_data = 32'hCAFE_0013;
    instruction_write = 32'h1;
    run_pc_in = 1'b1;
    fetch_step(32'h0);
    exp_mem[0] = 32'hCAFE_0013;
    exp_in_run = 1'b1;
    instruction_write = 32'h0;
    check("both_core_run", core_run, 1'b1);
    check("both_count", load_count, 16'd1);
    fetch_step(32'h0);

    do_write(32'h0, 32'hFFFF_FFFF);
    check("run_write_err", load_err, 1'b1);
    check("run_write_count", load_count, 16'd1);
    fetch_step(32'h0);

`ifdef IMEM_READBACK_EN
    readback_addr = 32'h0;
    step();
    check("readback_word0", readback_data, 32'hCAFE_0013);
    readback_addr = 32'h2000;
    step();
    check("readback_bad", readback_data, 32'hDEAD_BEEF);
    readback_addr = 32'h8;
    step();
    check("readback_word2", readback_data, NOP);
`endif

    run_pc_in = 1'b0;
    fetch_step(32'h0);
    exp_in_run = 1'b0;
    check("stop2_core_run", core_run, 1'b0);
    fetch_step(32'h0);

    // Reset asserted partway through a clear.
    mem_reset_n = 1'b0;
    step();
    check("midclr_state", state_o, 2'd0);
    mem_reset_n = 1'b1;
    repeat (500) step();
    reset_n = 1'b0;
    #1;
    check("arst_state", state_o, 2'd0);
    check("arst_core_run", core_run, 1'b0);
    check("arst_fetch", fetch_instr, NOP);
    check("arst_count", load_count, 16'd0);
    check("arst_err", load_err, 1'b0);
    repeat (2) step();
    reset_n = 1'b1;
    clear_len("clear_cycles_after_reset");

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
